// File: rtl/jstk_dir_tracker_if.sv
// Joystick tracker bundle: raw SPI samples in, move tokens out.
// The slave side is the tracker, the master side is the SPI/game glue.
interface jstk_dir_tracker_if #(
   parameter int DATA_W = 10
);
   logic              sample_vld;
   logic [DATA_W-1:0] pos_x;
   logic [DATA_W-1:0] pos_y;
   logic              move_valid;
   logic              move_ready;
   logic [2:0]        move_dir;
   logic [2:0]        cur_dir;

   modport master (
      output sample_vld,
      output pos_x,
      output pos_y,
      output move_ready,
      input  move_valid,
      input  move_dir,
      input  cur_dir
   );

   modport slave (
      input  sample_vld,
      input  pos_x,
      input  pos_y,
      input  move_ready,
      output move_valid,
      output move_dir,
      output cur_dir
   );
endinterface

// File: rtl/jstk_dir_tracker.sv
// Joystick-to-move decoder: per-axis hysteresis zones, N-sample qualifier,
// one token per deflection over valid/ready with optional auto-repeat.
module jstk_dir_tracker #(
   parameter int DATA_W      = 10,
   parameter int CENTRE      = 512,
   parameter int DEAD        = 150,
   parameter int HYST        = 16,
   parameter int STABLE_N    = 3,
   parameter bit REPEAT_EN   = 1'b0,
   parameter int REPEAT_DLY  = 10,
   parameter int REPEAT_RATE = 4,
   parameter bit INVERT_Y    = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   jstk_dir_tracker_if.slave bus
);
   localparam logic [2:0] DIR_UP    = 3'b000;
   localparam logic [2:0] DIR_RIGHT = 3'b001;
   localparam logic [2:0] DIR_DOWN  = 3'b010;
   localparam logic [2:0] DIR_LEFT  = 3'b011;
   localparam logic [2:0] DIR_NONE  = 3'b100;

   localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ?
                            REPEAT_DLY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);
   localparam int STB_W   = $clog2(STABLE_N + 1);

   localparam logic [DATA_W-1:0] CTR_CODE = DATA_W'(CENTRE);
   localparam logic [DATA_W-1:0] ENTER_TH = DATA_W'(DEAD);
   localparam logic [DATA_W-1:0] LEAVE_TH = DATA_W'(DEAD - HYST);
   localparam logic [STB_W-1:0]  STB_TGT  = STB_W'(STABLE_N);
   localparam logic [RPT_W-1:0]  RPT_FST  = RPT_W'(REPEAT_DLY);
   localparam logic [RPT_W-1:0]  RPT_NXT  = RPT_W'(REPEAT_RATE);

   typedef enum logic [1:0] {
      Z_CTR,
      Z_POS,
      Z_NEG
   } zone_t;

   typedef enum logic [1:0] {
      NEUTRAL,
      WAIT_ACK,
      HELD
   } state_t;

   state_t            state;
   zone_t             xZone;
   zone_t             yZone;
   logic [2:0]        prevCls;
   logic [STB_W-1:0]  stbCnt;
   logic [RPT_W-1:0]  rptCnt;
   logic              rptPhase;
   logic [2:0]        heldDir;
   logic              moveValid;
   logic [2:0]        moveDir;
   logic [2:0]        curDir;

   zone_t             xNext;
   zone_t             yNext;
   logic              xAct;
   logic              yAct;
   logic [2:0]        cls;
   logic [STB_W-1:0]  stbNext;
   logic              qual;
   logic              acc;
   state_t            effState;
   logic [RPT_W-1:0]  rptInc;
   logic              rptHit;
   logic              emit;
   logic              emitRpt;
   logic              toNeutral;
   logic              rptStep;

   // Magnitude is formed by subtracting the smaller code from the
   // larger one, so it never wraps at either end of the range.
   function automatic zone_t nextZone(
      input zone_t             z,
      input logic [DATA_W-1:0] pos
   );
      logic              neg;
      logic [DATA_W-1:0] mag;
      logic              out;
      logic              back;
      neg  = pos < CTR_CODE;
      mag  = neg ? CTR_CODE - pos : pos - CTR_CODE;
      out  = mag > ENTER_TH;
      back = mag <= LEAVE_TH;
      nextZone = z;
      unique case (z)
         Z_CTR: begin
            if (out) nextZone = neg ? Z_NEG : Z_POS;
         end
         Z_POS: begin
            if (out && neg) nextZone = Z_NEG;
            else if (back)  nextZone = Z_CTR;
         end
         Z_NEG: begin
            if (out && !neg) nextZone = Z_POS;
            else if (back)   nextZone = Z_CTR;
         end
         default: nextZone = Z_CTR;
      endcase
   endfunction

   always_comb begin
      xNext = nextZone(xZone, bus.pos_x);
      yNext = nextZone(yZone, bus.pos_y);
      xAct  = xNext != Z_CTR;
      yAct  = yNext != Z_CTR;
      cls   = DIR_NONE;
      unique case (1'b1)
         xAct && !yAct:
            cls = (xNext == Z_POS) ? DIR_RIGHT : DIR_LEFT;
         yAct && !xAct:
            cls = ((yNext == Z_POS) == INVERT_Y) ? DIR_UP : DIR_DOWN;
         default:
            cls = DIR_NONE;
      endcase
   end

   always_comb begin
      if (cls != prevCls)       stbNext = STB_W'(1);
      else if (stbCnt == STB_TGT) stbNext = stbCnt;
      else                      stbNext = stbCnt + STB_W'(1);
      qual = stbNext == STB_TGT;
   end

   // An accept on the same edge as a sample is applied first, so the
   // sample is judged as if the FSM were already in HELD.
   always_comb begin
      acc      = moveValid && bus.move_ready;
      effState = (state == WAIT_ACK && acc) ? HELD : state;
      rptInc   = rptCnt + RPT_W'(1);
      rptHit   = rptInc == (rptPhase ? RPT_NXT : RPT_FST);
   end

   always_comb begin
      emit      = 1'b0;
      emitRpt   = 1'b0;
      toNeutral = 1'b0;
      rptStep   = 1'b0;
      if (bus.sample_vld && qual) begin
         unique case (effState)
            NEUTRAL: begin
               emit = cls != DIR_NONE;
            end
            HELD: begin
               if (cls == DIR_NONE) begin
                  toNeutral = 1'b1;
               end else if (cls != heldDir) begin
                  emit = 1'b1;
               end else if (REPEAT_EN) begin
                  emit    = rptHit;
                  emitRpt = rptHit;
                  rptStep = !rptHit;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= NEUTRAL;
         xZone     <= Z_CTR;
         yZone     <= Z_CTR;
         prevCls   <= DIR_NONE;
         stbCnt    <= '0;
         rptCnt    <= '0;
         rptPhase  <= 1'b0;
         heldDir   <= DIR_NONE;
         moveValid <= 1'b0;
         moveDir   <= DIR_NONE;
         curDir    <= DIR_NONE;
      end else begin
         if (acc) begin
            moveValid <= 1'b0;
            moveDir   <= DIR_NONE;
            state     <= HELD;
         end
         if (bus.sample_vld) begin
            xZone   <= xNext;
            yZone   <= yNext;
            prevCls <= cls;
            stbCnt  <= stbNext;
            if (qual) curDir <= cls;
         end
         if (emit) begin
            moveValid <= 1'b1;
            moveDir   <= cls;
            heldDir   <= cls;
            state     <= WAIT_ACK;
            rptCnt    <= '0;
            rptPhase  <= emitRpt;
         end else if (toNeutral) begin
            state <= NEUTRAL;
         end else if (rptStep) begin
            rptCnt <= rptInc;
         end
      end
   end

   assign bus.move_valid = moveValid;
   assign bus.move_dir   = moveDir;
   assign bus.cur_dir    = curDir;
endmodule

// File: tb/tb_jstk_dir_tracker.sv
// Bench for jstk_dir_tracker: one instance without and one with auto-repeat,
// expected tokens queued by the stimulus and checked by per-instance monitors.
module tb_jstk_dir_tracker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   jstk_dir_tracker_if #(.DATA_W(10)) ifA ();
   jstk_dir_tracker_if #(.DATA_W(10)) ifB ();

   jstk_dir_tracker #(
      .DATA_W(10), .CENTRE(512), .DEAD(150), .HYST(16),
      .STABLE_N(3), .REPEAT_EN(1'b0), .REPEAT_DLY(10),
      .REPEAT_RATE(4), .INVERT_Y(1'b1)
   ) dutA (
      .clk(clk), .rst_n(rst_n), .bus(ifA)
   );

   jstk_dir_tracker #(
      .DATA_W(10), .CENTRE(512), .DEAD(150), .HYST(16),
      .STABLE_N(3), .REPEAT_EN(1'b1), .REPEAT_DLY(10),
      .REPEAT_RATE(4), .INVERT_Y(1'b1)
   ) dutB (
      .clk(clk), .rst_n(rst_n), .bus(ifB)
   );

   typedef struct packed {
      logic [2:0] dir;
      int         idx;
   } tok_t;

   tok_t qA[$];
   tok_t qB[$];
   int   checks = 0;
   int   passes = 0;
   int   sampleIdx = 0;
   bit   useA = 1'b1;
   bit   useB = 1'b0;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic tok_t mk(input logic [2:0] d, input int i);
      tok_t t;
      t.dir = d;
      t.idx = i;
      return t;
   endfunction

   // Token monitors plus stall-stability watch.
   logic       pvA = 1'b0, paA = 1'b0, pvB = 1'b0, paB = 1'b0;
   logic [2:0] pdA = 3'b100, pdB = 3'b100;

   always @(negedge clk) begin
      tok_t t;
      if (rst_n === 1'b1) begin
         if (ifA.move_valid && pvA && !paA)
            check("A stall dir stable", 32'(ifA.move_dir), 32'(pdA));
         if (ifA.move_valid && ifA.move_ready) begin
            if (qA.size() == 0) begin
               checks++;
               $display("FAIL A unexpected token: got dir %0d at sample %0d expected none",
                        ifA.move_dir, sampleIdx);
            end else begin
               t = qA.pop_front();
               check("A token dir", 32'(ifA.move_dir), 32'(t.dir));
               check("A token sample", sampleIdx, t.idx);
            end
         end
      end
      pvA = ifA.move_valid;
      pdA = ifA.move_dir;
      paA = ifA.move_ready;
   end

   always @(negedge clk) begin
      tok_t t;
      if (rst_n === 1'b1) begin
         if (ifB.move_valid && pvB && !paB)
            check("B stall dir stable", 32'(ifB.move_dir), 32'(pdB));
         if (ifB.move_valid && ifB.move_ready) begin
            if (qB.size() == 0) begin
               checks++;
               $display("FAIL B unexpected token: got dir %0d at sample %0d expected none",
                        ifB.move_dir, sampleIdx);
            end else begin
               t = qB.pop_front();
               check("B token dir", 32'(ifB.move_dir), 32'(t.dir));
               check("B token sample", sampleIdx, t.idx);
            end
         end
      end
      pvB = ifB.move_valid;
      pdB = ifB.move_dir;
      paB = ifB.move_ready;
   end

   task automatic setReady(input logic r);
      ifA.move_ready = r;
      ifB.move_ready = r;
   endtask

   task automatic doSample(input int x, input int y);
      @(posedge clk); #2;
      ifA.pos_x = 10'(x);
      ifA.pos_y = 10'(y);
      ifB.pos_x = 10'(x);
      ifB.pos_y = 10'(y);
      ifA.sample_vld = useA;
      ifB.sample_vld = useB;
      sampleIdx++;
      @(posedge clk); #2;
      ifA.sample_vld = 1'b0;
      ifB.sample_vld = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic doReset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      ifA.sample_vld = 1'b0;
      ifB.sample_vld = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
      sampleIdx = 0;
   endtask

   initial begin
      ifA.sample_vld = 1'b0;
      ifB.sample_vld = 1'b0;
      ifA.pos_x = 10'd512;
      ifA.pos_y = 10'd512;
      ifB.pos_x = 10'd512;
      ifB.pos_y = 10'd512;
      setReady(1'b1);

      // reset state and rest position
      doReset();
      check("A reset valid", 32'(ifA.move_valid), 0);
      check("A reset move_dir", 32'(ifA.move_dir), 4);
      check("A reset cur_dir", 32'(ifA.cur_dir), 4);
      check("B reset valid", 32'(ifB.move_valid), 0);
      check("B reset move_dir", 32'(ifB.move_dir), 4);
      check("B reset cur_dir", 32'(ifB.cur_dir), 4);
      useA = 1'b1;
      useB = 1'b0;
      for (int i = 0; i < 20; i++) doSample(512, 512);
      check("centre cur_dir", 32'(ifA.cur_dir), 4);

      // single token for a long right hold
      doReset();
      qA.push_back(mk(3'b001, 3));
      for (int i = 0; i < 33; i++) doSample(900, 512);
      check("held right cur_dir", 32'(ifA.cur_dir), 1);

      // dead-zone edge and hysteresis release
      doReset();
      for (int i = 0; i < 3; i++) doSample(662, 512);
      check("edge 662 cur_dir", 32'(ifA.cur_dir), 4);
      qA.push_back(mk(3'b001, 6));
      for (int i = 0; i < 3; i++) doSample(663, 512);
      check("enter 663 cur_dir", 32'(ifA.cur_dir), 1);
      for (int i = 0; i < 3; i++) doSample(647, 512);
      check("hyst 647 cur_dir", 32'(ifA.cur_dir), 1);
      for (int i = 0; i < 3; i++) doSample(646, 512);
      check("release 646 cur_dir", 32'(ifA.cur_dir), 4);
      qA.push_back(mk(3'b001, 15));
      for (int i = 0; i < 3; i++) doSample(663, 512);

      // diagonal, then up, then direct flip to down
      doReset();
      for (int i = 0; i < 3; i++) doSample(900, 900);
      check("diagonal cur_dir", 32'(ifA.cur_dir), 4);
      qA.push_back(mk(3'b000, 6));
      for (int i = 0; i < 3; i++) doSample(512, 900);
      check("up cur_dir", 32'(ifA.cur_dir), 0);
      qA.push_back(mk(3'b010, 9));
      for (int i = 0; i < 3; i++) doSample(512, 100);
      check("down cur_dir", 32'(ifA.cur_dir), 2);

      // left at code 0 held: both instances, repeat on B
      doReset();
      useB = 1'b1;
      qA.push_back(mk(3'b011, 3));
      qB.push_back(mk(3'b011, 3));
      qB.push_back(mk(3'b011, 13));
      qB.push_back(mk(3'b011, 17));
      qB.push_back(mk(3'b011, 21));
      qB.push_back(mk(3'b011, 25));
      qB.push_back(mk(3'b011, 29));
      for (int i = 0; i < 30; i++) doSample(0, 512);
      check("B left cur_dir", 32'(ifB.cur_dir), 3);
      useB = 1'b0;

      // stalled consumer, release under stall, reset mid-handshake
      doReset();
      setReady(1'b0);
      for (int i = 0; i < 3; i++) doSample(512, 100);
      repeat (50) @(posedge clk);
      for (int i = 0; i < 3; i++) doSample(512, 512);
      #1;
      check("stall valid held", 32'(ifA.move_valid), 1);
      check("stall dir held", 32'(ifA.move_dir), 2);
      check("stall cur_dir none", 32'(ifA.cur_dir), 4);
      @(posedge clk); #2;
      rst_n = 1'b0;
      @(posedge clk); #2;
      check("reset drops valid", 32'(ifA.move_valid), 0);
      check("reset drops dir", 32'(ifA.move_dir), 4);
      rst_n = 1'b1;
      sampleIdx = 0;
      setReady(1'b1);
      for (int i = 0; i < 4; i++) doSample(512, 512);

      repeat (5) @(posedge clk);
      check("A tokens outstanding", qA.size(), 0);
      check("B tokens outstanding", qB.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
